sysid_check_master: RTL and testbench

Avalon-MM read master that interrogates the system ID peripheral after boot or on request. It reads word 0 (system ID) and then word 1 (build timestamp), and compares both against values fixed at synthesis time. It reports pass or fail to the board-level status logic. It sits on the same Avalon fabric as the sysid slave and drives that slave's control port.

---
 rtl/sysid_check_master_if.sv | 21 ++
 rtl/sysid_check_master.sv | 149 ++++++++++++++
 tb/tb_sysid_check_master.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_check_master_if.sv
// rtl/sysid_check_master_if.sv - Avalon-MM read bus between the sysid check master and the sysid slave
interface sysid_check_master_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/sysid_check_master.sv
// rtl/sysid_check_master.sv - reads sysid words 0/1 and compares them to build-time constants
// Optional stall timeout compiled in with SYSID_CHECK_TIMEOUT_EN.
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID        = 32'd102,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1526569095,
    parameter logic [15:0] TIMEOUT_CYCLES     = 16'd1024
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    sysid_check_master_if.master        avm,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        id_mismatch,
    output logic                        ts_mismatch,
    output logic                        timeout,
    output logic [31:0]                 read_id,
    output logic [31:0]                 read_ts
);

    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;

    state_t      state, state_d;
    logic        read_d, addr_d, busy_d, done_d, pass_d;
    logic        idm_d, tsm_d, to_d;
    logic [31:0] rid_d, rts_d;
    logic        accept, stall, stall_limit;

    assign accept = avm.avm_read && !avm.avm_waitrequest;
    assign stall  = avm.avm_read &&  avm.avm_waitrequest;

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic [15:0] stall_cnt, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt;
        if (state == IDLE) begin
            if (start) stall_cnt_d = '0;
        end else if (accept) begin
            stall_cnt_d = '0;
        end else if (stall && (state == RD_ID || state == RD_TS)) begin
            stall_cnt_d = stall_cnt + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) stall_cnt <= '0;
        else       stall_cnt <= stall_cnt_d;
    end

    // Abort on the edge that closes the TIMEOUT_CYCLES-th consecutive stall cycle.
    assign stall_limit = stall && (stall_cnt == TIMEOUT_CYCLES - 16'd1);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign stall_limit        = 1'b0;
`endif

    always_comb begin
        state_d = state;
        read_d  = avm.avm_read;
        addr_d  = avm.avm_address;
        busy_d  = busy;
        done_d  = 1'b0;
        pass_d  = pass;
        idm_d   = id_mismatch;
        tsm_d   = ts_mismatch;
        to_d    = timeout;
        rid_d   = read_id;
        rts_d   = read_ts;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = RD_ID;
                    busy_d  = 1'b1;
                    read_d  = 1'b1;
                    addr_d  = 1'b0;
                    pass_d  = 1'b0;
                    idm_d   = 1'b0;
                    tsm_d   = 1'b0;
                    to_d    = 1'b0;
                end
            end
            RD_ID, RD_TS: begin
                if (accept) begin
                    if (state == RD_ID) begin
                        rid_d   = avm.avm_readdata;
                        idm_d   = (avm.avm_readdata != EXPECTED_ID);
                        addr_d  = 1'b1;
                        state_d = RD_TS;
                    end else begin
                        rts_d   = avm.avm_readdata;
                        tsm_d   = (avm.avm_readdata != EXPECTED_TIMESTAMP);
                        read_d  = 1'b0;
                        addr_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = !id_mismatch && (avm.avm_readdata == EXPECTED_TIMESTAMP);
                        state_d = DONE;
                    end
                end else if (stall_limit) begin
                    // Pending word's mismatch flag stays 0; only timeout reports the abort.
                    read_d  = 1'b0;
                    addr_d  = 1'b0;
                    to_d    = 1'b1;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            avm.avm_read    <= 1'b0;
            avm.avm_address <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            id_mismatch     <= 1'b0;
            ts_mismatch     <= 1'b0;
            timeout         <= 1'b0;
            read_id         <= '0;
            read_ts         <= '0;
        end else begin
            state           <= state_d;
            avm.avm_read    <= read_d;
            avm.avm_address <= addr_d;
            busy            <= busy_d;
            done            <= done_d;
            pass            <= pass_d;
            id_mismatch     <= idm_d;
            ts_mismatch     <= tsm_d;
            timeout         <= to_d;
            read_id         <= rid_d;
            read_ts         <= rts_d;
        end
    end

endmodule

// File: tb/tb_sysid_check_master.sv
// tb/tb_sysid_check_master.sv - scoreboard bench for sysid_check_master with a behavioural sysid slave
module tb_sysid_check_master;

    localparam logic [31:0] EXP_ID = 32'd102;
    localparam logic [31:0] EXP_TS = 32'd1526569095;
    localparam int          TMO    = 16;
`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam bit          TMO_EN = 1'b1;
`else
    localparam bit          TMO_EN = 1'b0;
`endif

    typedef struct {
        logic        pass;
        logic        idm;
        logic        tsm;
        logic        to;
        logic [31:0] rid;
        logic [31:0] rts;
        int          lat;
        int          sc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
    logic [31:0] read_id, read_ts;

    sysid_check_master_if avm();

    sysid_check_master #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .TIMEOUT_CYCLES     (16'(TMO))
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .avm         (avm),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .id_mismatch (id_mismatch),
        .ts_mismatch (ts_mismatch),
        .timeout     (timeout),
        .read_id     (read_id),
        .read_ts     (read_ts)
    );

    always #5 clock = ~clock;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_done = 0;
    int          n_push = 0;
    exp_t        q[$];
    logic [31:0] last_id = '0;
    logic [31:0] last_ts = '0;

    logic [31:0] slv_d0 = '0, slv_d1 = '0;
    int          st0 = 0, st1 = 0;
    bit          prev_stall = 1'b0;
    logic        prev_addr = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: what a check of slave words d0/d1 with w0/w1 stall cycles must report.
    function automatic exp_t model(input logic [31:0] d0, input logic [31:0] d1,
                                   input int w0, input int w1, input int sc);
        exp_t e;
        e.sc  = sc;
        e.to  = 1'b0;
        e.idm = 1'b0;
        e.tsm = 1'b0;
        e.rid = last_id;
        e.rts = last_ts;
        if (TMO_EN && w0 >= TMO) begin
            e.to  = 1'b1;
            e.lat = TMO;
        end else begin
            e.rid = d0;
            e.idm = (d0 != EXP_ID);
            if (TMO_EN && w1 >= TMO) begin
                e.to  = 1'b1;
                e.lat = 1 + w0 + TMO;
            end else begin
                e.rts = d1;
                e.tsm = (d1 != EXP_TS);
                e.lat = 2 + w0 + w1;
            end
        end
        e.pass  = !e.idm && !e.tsm && !e.to;
        last_id = e.rid;
        last_ts = e.rts;
        return e;
    endfunction

    // Sysid slave: stalls the requested number of cycles per word, garbage on readdata while stalling.
    initial begin
        avm.avm_waitrequest = 1'b0;
        avm.avm_readdata    = '0;
    end

    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
            avm.avm_waitrequest = 1'b0;
        end else begin
            if (prev_stall && !done) begin
                check("stall_read_held", {31'd0, avm.avm_read}, 32'd1);
                check("stall_addr_held", {31'd0, avm.avm_address}, {31'd0, prev_addr});
            end
            prev_addr = avm.avm_address;
            if (avm.avm_read) begin
                if (!avm.avm_address && st0 > 0) begin
                    avm.avm_waitrequest = 1'b1;
                    avm.avm_readdata    = $urandom;
                    st0--;
                end else if (avm.avm_address && st1 > 0) begin
                    avm.avm_waitrequest = 1'b1;
                    avm.avm_readdata    = $urandom;
                    st1--;
                end else begin
                    avm.avm_waitrequest = 1'b0;
                    avm.avm_readdata    = avm.avm_address ? slv_d1 : slv_d0;
                end
            end else begin
                avm.avm_waitrequest = 1'b0;
                avm.avm_readdata    = $urandom;
            end
            prev_stall = avm.avm_read && avm.avm_waitrequest;
        end
    end

    // Scoreboard monitor.
    always @(negedge clock) begin
        if (!reset && done) begin
            exp_t e;
            n_done++;
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("pass",        {31'd0, pass},        {31'd0, e.pass});
                check("id_mismatch", {31'd0, id_mismatch}, {31'd0, e.idm});
                check("ts_mismatch", {31'd0, ts_mismatch}, {31'd0, e.tsm});
                check("timeout",     {31'd0, timeout},     {31'd0, e.to});
                check("read_id",     read_id,              e.rid);
                check("read_ts",     read_ts,              e.rts);
                check("latency",     32'(cyc - e.sc),      32'(e.lat));
                check("busy_in_done", {31'd0, busy},       32'd1);
                check("read_low_in_done", {31'd0, avm.avm_read}, 32'd0);
            end
        end
    end

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic run_check(input logic [31:0] d0, input logic [31:0] d1,
                             input int w0, input int w1, input bit restart_mid);
        slv_d0 = d0;
        slv_d1 = d1;
        st0    = w0;
        st1    = w1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("busy_after_start",  {31'd0, busy},        32'd1);
        check("pass_cleared",      {31'd0, pass},        32'd0);
        check("idm_cleared",       {31'd0, id_mismatch}, 32'd0);
        check("tsm_cleared",       {31'd0, ts_mismatch}, 32'd0);
        check("timeout_cleared",   {31'd0, timeout},     32'd0);
        check("addr0_first",       {31'd0, avm.avm_address}, 32'd0);
        q.push_back(model(d0, d1, w0, w1, cyc));
        n_push++;
        if (restart_mid) begin
            repeat (w0 + 1) @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        wait_idle("check_completes");
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("rst_busy",    {31'd0, busy},          32'd0);
        check("rst_done",    {31'd0, done},          32'd0);
        check("rst_read",    {31'd0, avm.avm_read},  32'd0);
        check("rst_addr",    {31'd0, avm.avm_address}, 32'd0);
        check("rst_flags",   {28'd0, pass, id_mismatch, ts_mismatch, timeout}, 32'd0);
        check("rst_read_id", read_id, 32'd0);
        check("rst_read_ts", read_ts, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        run_check(EXP_ID, EXP_TS, 0, 0, 1'b0);
        run_check(32'd103, EXP_TS, 0, 0, 1'b0);
        run_check(EXP_ID, EXP_TS, 3, 2, 1'b0);
        run_check(EXP_ID, EXP_TS ^ 32'h8000_0000, 1, 2, 1'b1);
        repeat (1) @(negedge clock);
        run_check(EXP_ID, EXP_TS, 0, 1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] d0, d1;
            d0 = ($urandom_range(0, 1) == 0) ? EXP_ID : (EXP_ID ^ (32'd1 << $urandom_range(0, 31)));
            d1 = ($urandom_range(0, 1) == 0) ? EXP_TS : (EXP_TS ^ (32'd1 << $urandom_range(0, 31)));
            run_check(d0, d1, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        // Reset while word 0 is stalled.
        slv_d0 = EXP_ID;
        slv_d1 = EXP_TS;
        st0    = 5;
        st1    = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("midrst_read",    {31'd0, avm.avm_read}, 32'd0);
        check("midrst_busy",    {31'd0, busy},         32'd0);
        check("midrst_done",    {31'd0, done},         32'd0);
        check("midrst_flags",   {28'd0, pass, id_mismatch, ts_mismatch, timeout}, 32'd0);
        check("midrst_read_id", read_id, 32'd0);
        check("midrst_read_ts", read_ts, 32'd0);
        last_id = '0;
        last_ts = '0;
        repeat (2) @(negedge clock);
        st0   = 0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        run_check(EXP_ID, EXP_TS, 0, 0, 1'b0);

        // Slave stuck in waitrequest on word 0.
        if (TMO_EN) begin
            run_check(EXP_ID, EXP_TS, TMO + 40, 0, 1'b0);
            run_check(EXP_ID, EXP_TS, 2, TMO + 40, 1'b0);
            run_check(EXP_ID, EXP_TS, 0, 0, 1'b0);
        end else begin
            int done_before;
            done_before = n_done;
            st0 = 100000;
            @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            repeat (60) @(negedge clock);
            check("stuck_busy", {31'd0, busy},         32'd1);
            check("stuck_read", {31'd0, avm.avm_read}, 32'd1);
            check("stuck_no_done", 32'(n_done), 32'(done_before));
            reset = 1'b1;
            repeat (2) @(negedge clock);
            st0   = 0;
            reset = 1'b0;
        end

        repeat (4) @(negedge clock);
        check("done_count",  32'(n_done),   32'(n_push));
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
